// File: rtl/tnn_stream_classifier.sv
// Streaming ternary-weight classifier: one feature per beat feeds a hidden layer
// of ternary neurons, then a ternary output neuron; result is held until consumed.
// state | meaning
// ACCUM | accepting features, accumulating per-neuron weighted sums
// EVAL  | thresholding hidden neurons and output neuron, clearing accumulators
// DONE  | result presented on out_*, waiting for out_ready
module tnn_stream_classifier #(
    parameter int                        N_FEAT = 7,
    parameter int                        IN_W   = 2,
    parameter int                        N_HID  = 2,
    parameter logic [2*N_FEAT*N_HID-1:0] W_HID  = {14'h3FFF, 14'h1555},
    parameter logic [16*N_HID-1:0]       T_HID  = {16'hFFFD, 16'h0006},
    parameter logic [2*N_HID-1:0]        W_OUT  = 4'b1101,
    parameter logic [15:0]               T_OUT  = 16'h0001
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_class,
    output logic [N_HID-1:0] out_hidden
);
    localparam int ACC_W = IN_W + $clog2(N_FEAT + 1) + 1;
    localparam int CNT_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;

    typedef enum logic [1:0] {ACCUM, EVAL, DONE} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [ACC_W-1:0] acc_q [N_HID];
    logic signed [ACC_W-1:0] acc_d [N_HID];
    logic                    out_class_q, out_class_d;
    logic [N_HID-1:0]        out_hidden_q, out_hidden_d;

    logic signed [ACC_W-1:0] feat_ext;
    logic [1:0]              w_f;
    logic [N_HID-1:0]        hid_c;
    logic signed [15:0]      acc_ext;
    logic signed [15:0]      osum;

    assign in_ready   = (state_q == ACCUM);
    assign out_valid  = (state_q == DONE);
    assign out_class  = out_class_q;
    assign out_hidden = out_hidden_q;

    // Threshold evaluation is always computed; it is only captured in EVAL.
    always_comb begin
        hid_c   = '0;
        osum    = '0;
        acc_ext = '0;
        for (int h = 0; h < N_HID; h++) begin
            acc_ext  = {{(16 - ACC_W){acc_q[h][ACC_W-1]}}, acc_q[h]};
            hid_c[h] = (acc_ext >= $signed(T_HID[16*h +: 16]));
            if (hid_c[h]) begin
                if (W_OUT[2*h +: 2] == 2'b01)      osum = osum + 16'sd1;
                else if (W_OUT[2*h +: 2] == 2'b11) osum = osum - 16'sd1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        out_class_d  = out_class_q;
        out_hidden_d = out_hidden_q;
        feat_ext     = ACC_W'(in_data);
        w_f          = '0;

        case (state_q)
            ACCUM: begin
                if (in_valid) begin
                    for (int h = 0; h < N_HID; h++) begin
                        w_f = W_HID[2*(h*N_FEAT + int'(cnt_q)) +: 2];
                        if (w_f == 2'b01)      acc_d[h] = acc_q[h] + feat_ext;
                        else if (w_f == 2'b11) acc_d[h] = acc_q[h] - feat_ext;
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(N_FEAT - 1)) state_d = EVAL;
                end
            end
            EVAL: begin
                out_hidden_d = hid_c;
                out_class_d  = (osum >= $signed(T_OUT));
                for (int h = 0; h < N_HID; h++) acc_d[h] = '0;
                cnt_d   = '0;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = ACCUM;
            end
            default: state_d = ACCUM;
        endcase

        // Abort wins over any beat or handshake in the same cycle.
        if (flush) begin
            state_d      = ACCUM;
            cnt_d        = '0;
            out_class_d  = 1'b0;
            out_hidden_d = '0;
            for (int h = 0; h < N_HID; h++) acc_d[h] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ACCUM;
            cnt_q        <= '0;
            out_class_q  <= 1'b0;
            out_hidden_q <= '0;
            for (int h = 0; h < N_HID; h++) acc_q[h] <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            out_class_q  <= out_class_d;
            out_hidden_q <= out_hidden_d;
            for (int h = 0; h < N_HID; h++) acc_q[h] <= acc_d[h];
        end
    end
endmodule

// File: tb/tb_tnn_stream_classifier.sv
// Scoreboard bench for tnn_stream_classifier with default parameters.
module tb_tnn_stream_classifier;
    localparam logic [27:0] W_HID_M = {14'h3FFF, 14'h1555};
    localparam logic [31:0] T_HID_M = {16'hFFFD, 16'h0006};
    localparam logic [3:0]  W_OUT_M = 4'b1101;
    localparam logic [15:0] T_OUT_M = 16'h0001;

    logic       clk = 1'b0;
    logic       rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_class;
    logic [1:0] in_data, out_hidden;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [2:0] sb [$];

    tnn_stream_classifier dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_class(out_class), .out_hidden(out_hidden)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Independent reference: returns {hidden[1:0], class}
    function automatic logic [2:0] model(input logic [13:0] v);
        logic [27:0] wh;
        logic [31:0] th;
        logic [3:0]  wo;
        logic [1:0]  w;
        logic [1:0]  hid;
        int          acc, os;
        wh = W_HID_M; th = T_HID_M; wo = W_OUT_M;
        os = 0;
        for (int h = 0; h < 2; h++) begin
            acc = 0;
            for (int f = 0; f < 7; f++) begin
                w = wh[2*(h*7+f) +: 2];
                if (w == 2'b01)      acc += int'(v[2*f +: 2]);
                else if (w == 2'b11) acc -= int'(v[2*f +: 2]);
            end
            hid[h] = (acc >= int'($signed(th[16*h +: 16])));
            w = wo[2*h +: 2];
            if (hid[h] && w == 2'b01) os += 1;
            if (hid[h] && w == 2'b11) os -= 1;
        end
        return {hid, os >= int'($signed(T_OUT_M))};
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !flush) begin
            if (sb.size() == 0) check_val("sb_unexpected", 32'(sb.size()), 1);
            else begin
                logic [2:0] e;
                e = sb.pop_front();
                check_val("out_hidden", 32'(out_hidden), 32'(e[2:1]));
                check_val("out_class", 32'(out_class), 32'(e[0]));
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_vec(input logic [13:0] v, input bit push, input bit gaps);
        for (int f = 0; f < 7; f++) begin
            if (f == 6 && push) sb.push_back(model(v));
            in_valid = 1'b1;
            in_data  = v[2*f +: 2];
            tick();
            in_valid = 1'b0;
            if (gaps && f == 2) begin
                tick(); tick();
            end
        end
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!out_valid && n < 20) begin tick(); n++; end
        check_val(tag, 32'(out_valid), 1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!in_ready && n < 20) begin tick(); n++; end
        check_val(tag, 32'(in_ready), 1);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        #3;
        check_val("rst_in_ready", 32'(in_ready), 1);
        check_val("rst_out_valid", 32'(out_valid), 0);
        check_val("rst_out_class", 32'(out_class), 0);
        check_val("rst_out_hidden", 32'(out_hidden), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();

        // All ones, with latency check
        send_vec(14'h1555, 1'b1, 1'b0);
        check_val("lat_eval", 32'(out_valid), 0);
        tick();
        check_val("lat_done", 32'(out_valid), 1);
        check_val("done_in_ready", 32'(in_ready), 0);
        wait_idle("idle1");

        send_vec(14'h0000, 1'b1, 1'b0);
        wait_idle("idle2");
        send_vec(14'h000F, 1'b1, 1'b1);
        wait_idle("idle3");
        send_vec(14'h0155, 1'b1, 1'b0);
        wait_idle("idle4");
        send_vec(14'h0015, 1'b1, 1'b0);
        wait_idle("idle5");

        // Back-pressure: result held, beats refused
        out_ready = 1'b0;
        send_vec(14'h2AAA, 1'b1, 1'b0);
        wait_valid("hold_valid");
        in_valid = 1'b1; in_data = 2'd3;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("hold_valid_i", 32'(out_valid), 1);
            check_val("hold_in_ready", 32'(in_ready), 0);
            check_val("hold_hidden", 32'(out_hidden), 32'b01);
            check_val("hold_class", 32'(out_class), 1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_idle("idle6");
        send_vec(14'h0015, 1'b1, 1'b0);
        wait_idle("idle7");

        // Flush mid-vector; beat during flush must be ignored
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 2'd3; tick();
        end
        flush = 1'b1; in_data = 2'd3; tick();
        flush = 1'b0; in_valid = 1'b0;
        send_vec(14'h1555, 1'b1, 1'b0);
        wait_idle("idle8");

        // Flush in DONE discards result
        out_ready = 1'b0;
        send_vec(14'h1555, 1'b0, 1'b0);
        wait_valid("fl_valid");
        check_val("fl_pre_class", 32'(out_class), 1);
        flush = 1'b1; tick(); flush = 1'b0;
        check_val("fl_out_valid", 32'(out_valid), 0);
        check_val("fl_out_class", 32'(out_class), 0);
        check_val("fl_out_hidden", 32'(out_hidden), 0);
        check_val("fl_in_ready", 32'(in_ready), 1);

        // Reset in DONE
        send_vec(14'h1555, 1'b0, 1'b0);
        wait_valid("rd_valid");
        rst_n = 1'b0; #1;
        check_val("rd_out_valid", 32'(out_valid), 0);
        check_val("rd_out_class", 32'(out_class), 0);
        check_val("rd_out_hidden", 32'(out_hidden), 0);
        @(negedge clk); rst_n = 1'b1;
        tick();
        out_ready = 1'b1;

        // Reset mid-vector
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 2'd3; tick();
        end
        in_valid = 1'b0;
        rst_n = 1'b0; #1;
        check_val("rm_in_ready", 32'(in_ready), 1);
        check_val("rm_out_valid", 32'(out_valid), 0);
        @(negedge clk); rst_n = 1'b1;
        tick();
        send_vec(14'h0000, 1'b1, 1'b0);
        wait_idle("idle9");
        tick();
        check_val("sb_empty", 32'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
